// File: rtl/clz_div_pkg.sv
// ---------------------------------------------------------------------------
// clz_div_pkg
// Shared definitions for the leading-zero-skipping integer divider:
//   XLEN           operand width (the priority encoder fixes this at 32)
//   state_t        divider control states
//   DIV0_QUOTIENT  quotient returned for a zero divisor
//   neg_if()       two's-complement negate when the flag is set
// ---------------------------------------------------------------------------
package clz_div_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Conditional two's-complement negation, used for magnitude conversion
   // and for the final sign fix of quotient/remainder.
   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] value,
                                              input logic             negate);
      logic [XLEN-1:0] result;
      if (negate) begin
         result = ~value + 32'd1;
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage : clz_div_pkg

// File: rtl/priority_encoder32.sv
// ---------------------------------------------------------------------------
// PriorityEncoder32
// MSB-first priority encoder. The returned index is the number of leading
// zeros in the input; valid is low for an all-zero input (index then 0 and
// meaningless).
//   in_vec  input  32  vector to encode
//   index   output 5   leading-zero count of in_vec
//   valid   output 1   in_vec has at least one set bit
// ---------------------------------------------------------------------------
module PriorityEncoder32 (
   input  logic [31:0] in_vec,
   output logic [4:0]  index,
   output logic        valid
);

   logic [4:0] index_s;
   logic       found_s;

   // Scan from the MSB down; the first set bit fixes the leading-zero count.
   always_comb begin
      index_s = 5'd0;
      found_s = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (!found_s && in_vec[i]) begin
            index_s = 5'(31 - i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign index = index_s;
   assign valid = found_s;

endmodule : PriorityEncoder32

// File: rtl/clz_divider.sv
// ---------------------------------------------------------------------------
// clz_divider
// Multi-cycle 32-bit restoring divider. The divisor is pre-aligned to the
// dividend using leading-zero counts, so the shift-subtract loop only runs
// clz(divisor) - clz(dividend) + 1 iterations. Zero divisor and
// dividend < divisor finish one edge after accept.
//
// Optional build macro CLZ_DIVIDER_SIGNED_EN adds the is_signed input:
// operands are reduced to magnitudes, the quotient is negated when the
// operand signs differ and the remainder follows the dividend's sign.
//
// Ports:
//   clk        input   1     clock, rising edge
//   rst_n      input   1     asynchronous active-low reset
//   in_valid   input   1     operands present
//   in_ready   output  1     high only in IDLE
//   dividend   input   XLEN  numerator
//   divisor    input   XLEN  denominator
//   is_signed  input   1     signed operation (CLZ_DIVIDER_SIGNED_EN only)
//   out_valid  output  1     result present (DONE)
//   out_ready  input   1     consumer accepts result
//   quotient   output  XLEN  result quotient
//   remainder  output  XLEN  result remainder
//   busy       output  1     state != IDLE
// ---------------------------------------------------------------------------
module clz_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
`ifdef CLZ_DIVIDER_SIGNED_EN
   input  logic            is_signed,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            busy
);

   import clz_div_pkg::*;

   // The encoder is hard-wired to 32 bits.
   if (XLEN != clz_div_pkg::XLEN) begin : g_bad_xlen
      $error("clz_divider: XLEN must be 32");
   end

   state_t          state_r;
   state_t          state_nxt_s;

   logic [XLEN-1:0] rem_r;
   logic [XLEN-1:0] d_r;
   logic [XLEN-1:0] q_r;
   logic [4:0]      cnt_r;
   logic [XLEN-1:0] quotient_r;
   logic [XLEN-1:0] remainder_r;
   logic            neg_q_r;
   logic            neg_r_r;

   logic [XLEN-1:0] a_mag_s;
   logic [XLEN-1:0] b_mag_s;
   logic            neg_q_s;
   logic            neg_r_s;
   logic [4:0]      lz_a_s;
   logic [4:0]      lz_b_s;
   logic            a_nz_s;
   logic            b_nz_s;
   logic [4:0]      shift_s;
   logic            div0_s;
   logic            small_s;
   logic            accept_s;

   logic            ge_s;
   logic [XLEN-1:0] rem_nxt_s;
   logic [XLEN-1:0] q_nxt_s;

   // Operand magnitudes and sign bookkeeping, derived straight from the ports.
   always_comb begin
`ifdef CLZ_DIVIDER_SIGNED_EN
      neg_r_s = is_signed & dividend[XLEN-1];
      neg_q_s = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      a_mag_s = neg_if(dividend, neg_r_s);
      b_mag_s = neg_if(divisor, is_signed & divisor[XLEN-1]);
`else
      neg_r_s = 1'b0;
      neg_q_s = 1'b0;
      a_mag_s = dividend;
      b_mag_s = divisor;
`endif
   end

   PriorityEncoder32 u_enc_dividend (
      .in_vec (a_mag_s),
      .index  (lz_a_s),
      .valid  (a_nz_s)
   );

   PriorityEncoder32 u_enc_divisor (
      .in_vec (b_mag_s),
      .index  (lz_b_s),
      .valid  (b_nz_s)
   );

   // Encoder indices are only trusted for non-zero operands; the zero cases
   // are routed to the immediate-result path before the shift is used.
   assign div0_s   = ~b_nz_s;
   assign small_s  = ~a_nz_s | (a_mag_s < b_mag_s);
   assign shift_s  = lz_b_s - lz_a_s;
   assign accept_s = in_valid & (state_r == IDLE);

   // One restoring shift-subtract step on the current working registers.
   always_comb begin
      ge_s = (rem_r >= d_r);
      if (ge_s) begin
         rem_nxt_s = rem_r - d_r;
      end else begin
         rem_nxt_s = rem_r;
      end
      q_nxt_s = {q_r[XLEN-2:0], ge_s};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               if (div0_s || small_s) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == 5'd0) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_r)
         IDLE: in_ready = 1'b1;
         RUN:  busy     = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // Datapath: operand capture, iteration, and result latch with sign fix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r       <= 32'd0;
         d_r         <= 32'd0;
         q_r         <= 32'd0;
         cnt_r       <= 5'd0;
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
         quotient_r  <= 32'd0;
         remainder_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  if (div0_s) begin
                     quotient_r  <= DIV0_QUOTIENT;
                     remainder_r <= dividend;
                  end else if (small_s) begin
                     quotient_r  <= 32'd0;
                     remainder_r <= dividend;
                  end else begin
                     // shift <= clz(divisor) so the aligned divisor never overflows.
                     rem_r   <= a_mag_s;
                     d_r     <= b_mag_s << shift_s;
                     q_r     <= 32'd0;
                     cnt_r   <= shift_s;
                     neg_q_r <= neg_q_s;
                     neg_r_r <= neg_r_s;
                  end
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            RUN: begin
               rem_r <= rem_nxt_s;
               q_r   <= q_nxt_s;
               d_r   <= d_r >> 1;
               if (cnt_r == 5'd0) begin
                  quotient_r  <= neg_if(q_nxt_s, neg_q_r);
                  remainder_r <= neg_if(rem_nxt_s, neg_r_r);
               end else begin
                  cnt_r <= cnt_r - 5'd1;
               end
            end
            DONE: begin
               quotient_r  <= quotient_r;
               remainder_r <= remainder_r;
            end
            default: begin
               cnt_r <= 5'd0;
            end
         endcase
      end
   end

   assign quotient  = quotient_r;
   assign remainder = remainder_r;

endmodule : clz_divider

// File: tb/tb_clz_divider.sv
// ---------------------------------------------------------------------------
// tb_clz_divider
// Directed self-checking bench for clz_divider. Latency is counted in
// rising edges, the accept edge being edge 1.
// ---------------------------------------------------------------------------
module tb_clz_divider;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
`ifdef CLZ_DIVIDER_SIGNED_EN
   logic        is_signed;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;

   int checks;
   int errors;

   clz_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef CLZ_DIVIDER_SIGNED_EN
      .is_signed (is_signed),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present operands for one accept edge, then drop in_valid.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count edges (accept edge = 1) until out_valid, bounded.
   task automatic wait_done(output int edges);
      edges = 1;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL rst_quotient: got %h want 0", quotient); end
      checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL rst_remainder: got %h want 0", remainder); end
   endtask

   // Normal and immediate-result vectors: a, b, q, r, latency.
   task automatic test_vectors();
      logic [31:0] va [8];
      logic [31:0] vb [8];
      logic [31:0] vq [8];
      logic [31:0] vr [8];
      int          vl [8];
      int          edges;
      va[0] = 32'd100;        vb[0] = 32'd7;          vq[0] = 32'd14;         vr[0] = 32'd2;    vl[0] = 6;
      va[1] = 32'd5;          vb[1] = 32'd9;          vq[1] = 32'd0;          vr[1] = 32'd5;    vl[1] = 1;
      va[2] = 32'd0;          vb[2] = 32'd3;          vq[2] = 32'd0;          vr[2] = 32'd0;    vl[2] = 1;
      va[3] = 32'hFFFF_FFFF;  vb[3] = 32'd1;          vq[3] = 32'hFFFF_FFFF;  vr[3] = 32'd0;    vl[3] = 33;
      va[4] = 32'h8000_0000;  vb[4] = 32'h8000_0000;  vq[4] = 32'd1;          vr[4] = 32'd0;    vl[4] = 2;
      va[5] = 32'd1234;       vb[5] = 32'd0;          vq[5] = 32'hFFFF_FFFF;  vr[5] = 32'd1234; vl[5] = 1;
      va[6] = 32'd12345678;   vb[6] = 32'd1000;       vq[6] = 32'd12345;      vr[6] = 32'd678;  vl[6] = 16;
      va[7] = 32'd9;          vb[7] = 32'd3;          vq[7] = 32'd3;          vr[7] = 32'd0;    vl[7] = 4;
      for (int i = 0; i < 8; i++) begin
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready: got %b want 1", i, in_ready); end
         start_op(va[i], vb[i]);
         wait_done(edges);
         checks++; if (edges != vl[i]) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, edges, vl[i]); end
         checks++; if (quotient !== vq[i]) begin errors++; $display("FAIL vec%0d_quotient: got %h want %h", i, quotient, vq[i]); end
         checks++; if (remainder !== vr[i]) begin errors++; $display("FAIL vec%0d_remainder: got %h want %h", i, remainder, vr[i]); end
         consume();
         checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL vec%0d_release: got out_valid=%b busy=%b want 0 0", i, out_valid, busy); end
      end
   endtask

   // in_valid stays high through RUN and DONE with different operands; the
   // result must belong to the first operation, and DONE must hold stable.
   task automatic test_busy_hold();
      int edges;
      dividend = 32'd100;
      divisor  = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      dividend = 32'd5;
      divisor  = 32'd9;
      wait_done(edges);
      checks++; if (edges != 6) begin errors++; $display("FAIL hold_latency: got %0d want 6", edges); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_handshake: got out_valid=%b in_ready=%b want 1 0", i, out_valid, in_ready); end
         checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin errors++; $display("FAIL hold%0d_result: got q=%h r=%h want q=e r=2", i, quotient, remainder); end
      end
      in_valid = 1'b0;
      consume();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_capture: got busy=%b want 0", busy); end
   endtask

   // Reset in the middle of a long operation discards it; next op is clean.
   task automatic test_reset_mid_run();
      int edges;
      start_op(32'd1000, 32'd3);
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
      rst_n = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_state: got out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready); end
      checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin errors++; $display("FAIL midrst_outputs: got q=%h r=%h want 0 0", quotient, remainder); end
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_op(32'd9, 32'd3);
      wait_done(edges);
      checks++; if (edges != 4) begin errors++; $display("FAIL midrst_next_latency: got %0d want 4", edges); end
      checks++; if (quotient !== 32'd3 || remainder !== 32'd0) begin errors++; $display("FAIL midrst_next_result: got q=%h r=%h want 3 0", quotient, remainder); end
      consume();
   endtask

`ifdef CLZ_DIVIDER_SIGNED_EN
   task automatic test_signed();
      int edges;
      is_signed = 1'b1;
      start_op(32'hFFFF_FFF9, 32'd2);
      wait_done(edges);
      checks++; if (edges != 3) begin errors++; $display("FAIL sgn_m7_latency: got %0d want 3", edges); end
      checks++; if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sgn_m7_result: got q=%h r=%h want fffffffd ffffffff", quotient, remainder); end
      consume();
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(edges);
      checks++; if (edges != 33) begin errors++; $display("FAIL sgn_ovf_latency: got %0d want 33", edges); end
      checks++; if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin errors++; $display("FAIL sgn_ovf_result: got q=%h r=%h want 80000000 0", quotient, remainder); end
      consume();
      is_signed = 1'b0;
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = 32'd0;
      divisor   = 32'd0;
`ifdef CLZ_DIVIDER_SIGNED_EN
      is_signed = 1'b0;
`endif
      test_reset();
      test_vectors();
      test_busy_hold();
      test_reset_mid_run();
`ifdef CLZ_DIVIDER_SIGNED_EN
      test_signed();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_clz_divider
